// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: walks the register file debug port and streams every register as LSB-first bytes
module regfile_dump_unit #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4:0]           rs_dbg_addr_o,
    input  logic [REG_WIDTH-1:0] rs_dbg_data_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i
);
    localparam int BYTES = REG_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LATCH, SEND, DONE} state_t;

    state_t               r_state;
    logic [4:0]           r_reg_idx;
    logic [BW-1:0]        r_byte_idx;
    logic [REG_WIDTH-1:0] r_shift;
    logic                 w_hs;

    assign w_hs          = (r_state == SEND) && tx_ready_i;
    assign busy_o        = (r_state == LATCH) || (r_state == SEND);
    assign done_o        = (r_state == DONE);
    assign tx_valid_o    = (r_state == SEND);
    assign tx_data_o     = r_shift[7:0];
    assign rs_dbg_addr_o = r_reg_idx;

    // sequencer: reset outranks abort, abort outranks the walk; abort keeps the shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else if (abort_i) begin
            r_state    <= IDLE;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_reg_idx <= '0;
                        r_state   <= LATCH;
                    end
                end
                LATCH: begin
                    r_shift    <= rs_dbg_data_i;
                    r_byte_idx <= '0;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_byte_idx != BW'(BYTES - 1)) begin
                            r_shift    <= r_shift >> 8;
                            r_byte_idx <= r_byte_idx + BW'(1);
                        end else if (r_reg_idx != 5'(NUM_REGS - 1)) begin
                            r_reg_idx <= r_reg_idx + 5'd1;
                            r_state   <= LATCH;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    r_reg_idx <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: scoreboard bench for the register dump streamer
module tb_regfile_dump_unit;
    logic        clk = 0, rst_n = 0, start_i = 0, abort_i = 0, tx_ready_i = 1;
    logic        busy_o, done_o, tx_valid_o;
    logic [4:0]  rs_dbg_addr_o;
    logic [31:0] rs_dbg_data_i;
    logic [7:0]  tx_data_o;
    logic [31:0] regs [32];

    typedef struct packed {logic [7:0] d; logic [4:0] a;} exp_t;
    exp_t sb[$];

    int total = 0, bad = 0, hs = 0, done_cnt = 0, done_cyc = 0, cyc = 0, s_cyc = 0;
    int h0, d0;
    logic prev_v = 0, prev_r = 0, prev_ab = 0, prev_rn = 0;
    logic [7:0] prev_d = 0;

    regfile_dump_unit #(.REG_WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .rs_dbg_addr_o(rs_dbg_addr_o),
        .rs_dbg_data_i(rs_dbg_data_i), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rs_dbg_data_i = regs[rs_dbg_addr_o];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @cyc=%0d", n, act, exp, cyc);
        end
    endtask

    task automatic push_dump();
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++)
                sb.push_back({regs[r][8*b +: 8], 5'(r)});
    endtask

    task automatic start_dump();
        @(posedge clk); #1 start_i = 1;
        @(posedge clk); #1 start_i = 0;
        s_cyc = cyc;
    endtask

    task automatic at_cyc(input int k);
        while (cyc < s_cyc + k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int exp, input string n);
        int k = 0;
        int d = done_cnt;
        while (done_cnt == d && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d) begin
            total++; bad++;
            $display("FAIL %s_timeout got=no_done want=done", n);
        end else chk(n, done_cyc - s_cyc, exp);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // monitor: pops the scoreboard on every handshake and checks valid/data hold under backpressure
    always @(negedge clk) begin
        exp_t e;
        if (prev_v && !prev_r && !prev_ab && prev_rn) begin
            chk("hold_valid", tx_valid_o, 1);
            chk("hold_data", tx_data_o, prev_d);
        end
        if (tx_valid_o && tx_ready_i && rst_n && !abort_i) begin
            hs++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_byte got=%h want=none", tx_data_o);
            end else begin
                e = sb.pop_front();
                chk("byte", tx_data_o, e.d);
                chk("addr", rs_dbg_addr_o, e.a);
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", busy_o, 0);
        end
        prev_v = tx_valid_o; prev_r = tx_ready_i; prev_ab = abort_i; prev_rn = rst_n; prev_d = tx_data_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 0;
        regs[1]  = 32'h11223344;
        regs[31] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", tx_valid_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_addr", rs_dbg_addr_o, 0);

        // full dump, ready always high
        push_dump(); h0 = hs;
        start_dump();
        @(negedge clk);
        chk("c1_busy", busy_o, 1);
        chk("c1_valid", tx_valid_o, 0);
        @(negedge clk);
        chk("c2_valid", tx_valid_o, 1);
        wait_done(160, "t1_done_cyc");
        chk("t1_hs", hs - h0, 128);
        chk("t1_sb_empty", sb.size(), 0);

        // backpressure for 10 cycles at byte 6
        push_dump(); h0 = hs;
        start_dump();
        at_cyc(8);
        tx_ready_i = 0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", tx_valid_o, 1);
            chk("bp_data", tx_data_o, 8'h22);
            @(posedge clk); #1;
        end
        tx_ready_i = 1;
        wait_done(170, "t2_done_cyc");
        chk("t2_hs", hs - h0, 128);
        chk("t2_sb_empty", sb.size(), 0);

        // x5 rewritten the cycle after it was latched
        regs[5] = 32'hAAAA5555;
        push_dump();
        start_dump();
        at_cyc(26);
        regs[5] = 32'h12345678;
        wait_done(160, "t3_done_cyc");
        chk("t3_sb_empty", sb.size(), 0);

        // abort at byte 50 with the handshake pending
        push_dump(); h0 = hs;
        start_dump();
        at_cyc(63);
        tx_ready_i = 0;
        abort_i = 1;
        @(negedge clk);
        chk("t4_hs_before", hs - h0, 50);
        @(posedge clk); #1;
        abort_i = 0; tx_ready_i = 1; d0 = done_cnt;
        sb.delete();
        @(negedge clk);
        chk("t4_valid", tx_valid_o, 0);
        chk("t4_busy", busy_o, 0);
        chk("t4_addr", rs_dbg_addr_o, 0);
        repeat (5) @(negedge clk);
        chk("t4_no_done", done_cnt - d0, 0);
        push_dump(); h0 = hs;
        start_dump();
        wait_done(160, "t4_restart_done_cyc");
        chk("t4_restart_hs", hs - h0, 128);

        // start pulse during SEND of x10 is ignored
        push_dump(); d0 = done_cnt;
        start_dump();
        at_cyc(52);
        start_i = 1;
        @(posedge clk); #1 start_i = 0;
        wait_done(160, "t5_done_cyc");
        repeat (20) @(negedge clk);
        chk("t5_one_done", done_cnt - d0, 1);
        chk("t5_idle", busy_o, 0);

        // reset for one cycle while x5 bytes stream
        push_dump();
        start_dump();
        at_cyc(27);
        rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        sb.delete();
        @(negedge clk);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_valid", tx_valid_o, 0);
        chk("t6_data", tx_data_o, 0);
        chk("t6_addr", rs_dbg_addr_o, 0);

        // abort and start together in IDLE: nothing starts
        h0 = hs; d0 = done_cnt;
        @(posedge clk); #1 start_i = 1; abort_i = 1;
        @(posedge clk); #1 start_i = 0; abort_i = 0;
        repeat (4) begin
            @(negedge clk);
            chk("t7_busy", busy_o, 0);
            chk("t7_valid", tx_valid_o, 0);
        end
        chk("t7_hs", hs - h0, 0);
        chk("t7_done", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
